// File: rtl/hub75_pkg.sv
// hub75_pkg: shared widths and FSM encoding for the HUB75 capture block.
//   COLS_W  - column index width (64 columns)
//   ROW_W   - row address width
//   RGB_W   - {r1,g1,b1,r2,g2,b2} pixel width
//   PLANES  - number of brightness bit-planes per row
//   PLANE_W - plane index width
package hub75_pkg;
    localparam int COLS_W  = 6;
    localparam int ROW_W   = 4;
    localparam int RGB_W   = 6;
    localparam int PLANES  = 6;
    localparam int PLANE_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_OE = 2'd1,
        DRAIN   = 2'd2
    } state_t;
endpackage

// File: rtl/edge_sync.sv
// edge_sync: two-flop synchroniser for one asynchronous pin plus a third
// flop used to detect edges on the synchronised level.
//   clk, reset  - capture clock, synchronous active-high reset
//   din         - asynchronous pin
//   level       - synchronised pin level
//   rise / fall - one-cycle pulses on synchronised edges
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [2:0] sr;

    always_ff @(posedge clk) begin
        if (reset) sr <= '0;
        else       sr <= {sr[1:0], din};
    end

    assign level = sr[1];
    assign rise  = sr[1] & ~sr[2];
    assign fall  = ~sr[1] & sr[2];
endmodule

// File: rtl/hub75_capture.sv
// hub75_capture: oversampling HUB75 receiver. Rebuilds each shifted row,
// and after the row's OE pulse starts, replays it as 64 bit-plane writes.
//   clk_in, reset            - capture clock, synchronous active-high reset
//   hub75_clk/lat/oe         - asynchronous pixel clock, latch, output enable
//   hub75_row, hub75_rgb     - row address and pixel data (delay-matched)
//   status_clear             - clears the sticky error flags
//   wr_en/row/col/plane/data - frame-buffer write port, one write per cycle
//   oe_cycles                - width of the last completed OE pulse
//   err_*                    - sticky error flags
module hub75_capture
    import hub75_pkg::*;
#(
    parameter int COLS       = 64,
    parameter int OVERSAMPLE = 4,
    parameter int OE_TOL     = 2
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               hub75_clk,
    input  logic               hub75_lat,
    input  logic               hub75_oe,
    input  logic [ROW_W-1:0]   hub75_row,
    input  logic [RGB_W-1:0]   hub75_rgb,
    input  logic               status_clear,
    output logic               wr_en,
    output logic [ROW_W-1:0]   wr_row,
    output logic [COLS_W-1:0]  wr_col,
    output logic [PLANE_W-1:0] wr_plane,
    output logic [RGB_W-1:0]   wr_data,
    output logic [7:0]         oe_cycles,
    output logic               err_short_row,
    output logic               err_overrun,
    output logic               err_oe_width,
    output logic               err_missed_oe
);
    // bit 0 = pixel clock, bit 1 = latch, bit 2 = output enable
    logic [2:0] lvl, rise, fall;

    edge_sync u_sync [2:0] (
        .clk   (clk_in),
        .reset (reset),
        .din   ({hub75_oe, hub75_lat, hub75_clk}),
        .level (lvl),
        .rise  (rise),
        .fall  (fall)
    );

    logic pix_rise, lat_rise, oe_rise, oe_fall, oe_level;
    assign pix_rise = rise[0];
    assign lat_rise = rise[1];
    assign oe_rise  = rise[2];
    assign oe_fall  = fall[2];
    assign oe_level = lvl[2];

    // spare edge outputs not needed by this block
    logic unused;
    assign unused = ^{lvl[1:0], fall[1:0]};

    // Data/row delay lines are as deep as the edge path; the oldest tap is the
    // value sampled just before the edge was seen, i.e. set up ahead of it.
    logic [2:0][RGB_W-1:0] rgb_dl;
    logic [2:0][ROW_W-1:0] row_dl;

    logic [COLS-1:0][RGB_W-1:0] shreg, shreg_nx, hold;
    logic [6:0]                 pix_cnt, pix_cnt_nx;

    // The same-cycle shift is folded in before a latch copies the row.
    always_comb begin
        shreg_nx   = shreg;
        pix_cnt_nx = pix_cnt;
        if (pix_rise) begin
            shreg_nx = {shreg[COLS-2:0], rgb_dl[2]};
            if (pix_cnt != 7'd127) pix_cnt_nx = pix_cnt + 7'd1;
        end
    end

    state_t             state, state_nx;
    logic [COLS_W-1:0]  col;
    logic               start;
    logic [ROW_W-1:0]   cur_row, last_row;
    logic [PLANE_W-1:0] cur_plane, last_plane, plane_nx;

    always_ff @(posedge clk_in) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        wr_en    = 1'b0;
        unique case (state)
            IDLE:    if (lat_rise) state_nx = WAIT_OE;
            WAIT_OE: begin
                if (!lat_rise && oe_rise) begin
                    state_nx = DRAIN;
                    start    = 1'b1;
                end
            end
            DRAIN: begin
                wr_en = 1'b1;
                if (lat_rise)                         state_nx = WAIT_OE;
                else if (col == COLS_W'(COLS - 1))    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // last_plane resets to the top plane so the first row after reset lands
    // on plane 0 whether or not its address matches last_row.
    always_comb begin
        if (row_dl[2] != last_row || last_plane == PLANE_W'(PLANES - 1))
            plane_nx = '0;
        else
            plane_nx = last_plane + PLANE_W'(1);
    end

    // OE width check against the plane of the row being displayed.
    logic [7:0] oe_cnt;
    int         oe_err_amt;
    logic       oe_bad;
    always_comb begin
        oe_err_amt = int'(oe_cnt) - (OVERSAMPLE << cur_plane);
        oe_bad     = (oe_err_amt > OE_TOL) || (oe_err_amt < -OE_TOL);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            rgb_dl        <= '0;
            row_dl        <= '0;
            shreg         <= '0;
            hold          <= '0;
            pix_cnt       <= '0;
            col           <= '0;
            cur_row       <= '0;
            cur_plane     <= '0;
            last_row      <= '0;
            last_plane    <= PLANE_W'(PLANES - 1);
            oe_cnt        <= '0;
            oe_cycles     <= '0;
            err_short_row <= 1'b0;
            err_overrun   <= 1'b0;
            err_oe_width  <= 1'b0;
            err_missed_oe <= 1'b0;
        end else begin
            rgb_dl  <= {rgb_dl[1:0], hub75_rgb};
            row_dl  <= {row_dl[1:0], hub75_row};
            shreg   <= shreg_nx;
            pix_cnt <= lat_rise ? 7'd0 : pix_cnt_nx;
            if (lat_rise) hold <= shreg_nx;

            if (start)               col <= '0;
            else if (state == DRAIN) col <= col + COLS_W'(1);

            if (start) begin
                cur_row    <= row_dl[2];
                cur_plane  <= plane_nx;
                last_row   <= row_dl[2];
                last_plane <= plane_nx;
            end

            if (oe_rise)                         oe_cnt <= 8'd1;
            else if (oe_level && oe_cnt != 8'hff) oe_cnt <= oe_cnt + 8'd1;
            if (oe_fall) oe_cycles <= oe_cnt;

            // clear first, then set, so a coincident set is kept
            err_short_row <= (err_short_row & ~status_clear)
                           | (lat_rise && pix_cnt_nx != 7'(COLS));
            err_overrun   <= (err_overrun & ~status_clear)
                           | (lat_rise && state == DRAIN);
            err_missed_oe <= (err_missed_oe & ~status_clear)
                           | (lat_rise && state == WAIT_OE);
            err_oe_width  <= (err_oe_width & ~status_clear)
                           | (oe_fall && oe_bad);
        end
    end

    assign wr_row   = cur_row;
    assign wr_col   = col;
    assign wr_plane = cur_plane;
    assign wr_data  = wr_en ? hold[col] : '0;
endmodule

// File: doc/hub75_capture.md
# hub75_capture

Receive-side counterpart of the panel scan driver. Oversamples a HUB75-style bus (pixel clock, row latch, output enable, row address, 6-bit RGB), reconstructs each shifted row and emits it as 64 bit-plane writes to a frame-buffer write port. It sits behind the panel connector in loopback and daisy-chain builds, and is also used as a bench monitor for the scan driver.

## Interface
- `COLS`, 64: pixels per row; the shift depth.
- `OVERSAMPLE`, 4: `clk_in` cycles per driver clock; minimum 4.
- `OE_TOL`, 2: allowed ± error, in `clk_in` cycles, on an OE pulse width.
- `clk_in` in 1: capture clock.
- `reset` in 1: synchronous, active-high.
- `hub75_clk` in 1: pixel clock. Asynchronous.
- `hub75_lat` in 1: row latch. Asynchronous.
- `hub75_oe` in 1: output enable, high = LEDs on. Asynchronous.
- `hub75_row` in 4: row address.
- `hub75_rgb` in 6: {r1,g1,b1,r2,g2,b2}.
- `status_clear` in 1: clears the sticky error flags.
- `wr_en` out 1: one write per cycle when high.
- `wr_row` out 4: row of the write.
- `wr_col` out 6: column of the write.
- `wr_plane` out 3: brightness bit-plane, 0..5.
- `wr_data` out 6: RGB bits for (row, col, plane).
- `oe_cycles` out 8: width of the last completed OE pulse, in `clk_in` cycles.
- `err_short_row` out 1: sticky.
- `err_overrun` out 1: sticky.
- `err_oe_width` out 1: sticky.
- `err_missed_oe` out 1: sticky.

## Operation
- Every async input passes through 2 flops, then a 3rd flop for edge detect. `hub75_rgb` and `hub75_row` use the same pipeline depth, so data stays aligned with the clock edges.
- On a pixel clock rise:
  - shift `hub75_rgb` into the shift register at position 0; older entries move up.
  - increment `pix_cnt`, saturating at 127.
- The driver shifts column 63 first. After 64 shifts, position i holds column i.
- On a latch rise:
  - copy the shift register into `hold`.
  - set `err_short_row` if `pix_cnt` ≠ `COLS`.
  - clear `pix_cnt`.
  - FSM goes to WAIT_OE.
- FSM states, reset to IDLE:
  - IDLE: wait for a latch rise.
  - WAIT_OE: on an OE rise, capture `hub75_row` as `cur_row` and compute the plane (below), then go to DRAIN. A latch rise here sets `err_missed_oe`, reloads `hold` and stays in WAIT_OE.
  - DRAIN: `wr_en`=1 for 64 consecutive cycles with `wr_col` = 0..63, `wr_data` = `hold[wr_col]`, `wr_row` = `cur_row`, `wr_plane` = current plane. Then go to IDLE. A latch rise during DRAIN sets `err_overrun`, reloads `hold`, abandons the remaining writes and goes to WAIT_OE.
- Plane tracking:
  - if `cur_row` ≠ `last_row`, or after reset: plane = 0.
  - otherwise plane = `last_plane`+1, wrapping 5 → 0.
  - then `last_row` ← `cur_row`.
- OE width:
  - count runs independently of the FSM, from an OE rise to the next OE fall, saturating at 255.
  - on the fall, the count loads into `oe_cycles`.
  - `err_oe_width` is set if |count − 2^plane·`OVERSAMPLE`| > `OE_TOL`, using the plane of the current row.
- `status_clear` clears all four flags. If clear and a set fall in the same cycle, set wins.

## Timing
- Edge recognised 3 `clk_in` cycles after the pin changes.
- First `wr_en` appears 1 cycle after the OE rise is recognised.
- DRAIN takes exactly 64 cycles. The driver's row period of at least 65 driver clocks times `OVERSAMPLE` guarantees no overrun in normal use.
- The driver sends 64 pixel rises per row, each ≥ `OVERSAMPLE` cycles apart, and one shift happens per recognised rise.
- Reset values:
  - `wr_en`=0, `wr_row`=0, `wr_col`=0, `wr_plane`=0, `wr_data`=0.
  - `oe_cycles`=0, all flags 0.
  - FSM IDLE, `pix_cnt`=0, `last_row`=0, next plane 0.
  - synchroniser flops 0, so a pin already high at release gives a rise edge 3 cycles later.
- Reset mid-DRAIN: `wr_en` drops on the cycle after reset is sampled. The partial row is not resumed.
- A pixel rise and a latch rise in the same cycle: the shift happens first, and the latched copy includes the new pixel.

## Structure
- Package `hub75_pkg`:
  - `COLS_W`=6, `ROW_W`=4, `RGB_W`=6, `PLANES`=6, `PLANE_W`=3.
  - FSM state enum {IDLE, WAIT_OE, DRAIN}.
- Sub-module `edge_sync`: 2-flop synchroniser plus edge register, outputs `level`, `rise`, `fall`. One instance each for clk, lat and oe. The data and row buses use plain 3-deep delay lines.

## Test plan
- 64 pixel clocks with pixel k = k[5:0], then latch, then OE for 4 cycles, row 3 → 64 writes `wr_row`=3, `wr_plane`=0, `wr_col`=c, `wr_data`=63−c. No flags.
- Six rows at row 3 with OE widths 4,8,16,32,64,128, then row 4 → planes 0..5, then plane 0 for row 4. `oe_cycles` matches each width. No `err_oe_width`.
- 63 pixels then latch → `err_short_row`=1. `status_clear` → 0.
- Latch, OE rise, then a second latch 20 cycles into DRAIN → `err_overrun`=1, only 20 writes from the first row, and the new row drains after the next OE.
- Two latches with no OE between them → `err_missed_oe`=1. Only the second row is written.
- Plane 2 with OE width 13 at `OVERSAMPLE`=4 → `err_oe_width`=1, `oe_cycles`=13.
